// File: rtl/pot_scan_pkg.sv
// Shared types and constants for the slide-pot round-robin scanner.
// Slot names index the pot slots as the equalizer consumers see them.
package pot_scan_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_UPD  = 2'd3
    } state_t;

    // Slot 0 sits in the LSBs: slot0->1, 1->0, 2->4, 3->2, 4->3, 5->7.
    localparam logic [17:0] CH_MAP_DEF = {3'd7, 3'd3, 3'd2, 3'd4, 3'd0, 3'd1};

    localparam int LP  = 0;
    localparam int B1  = 1;
    localparam int B2  = 2;
    localparam int B3  = 3;
    localparam int HP  = 4;
    localparam int VOL = 5;

    function automatic logic [2:0] slot_next(input logic [2:0] slot, input int num_ch);
        return (int'(slot) == num_ch - 1) ? 3'd0 : slot + 3'd1;
    endfunction

endpackage

// File: rtl/pot_avg_hyst.sv
// Shared accumulator, averaging shift and hysteresis compare for pot_scan.
// The accumulator is sized so 2^AVG_LOG2 full-scale samples cannot overflow.
module pot_avg_hyst #(
    parameter int DATA_W   = 12,
    parameter int AVG_LOG2 = 2,
    parameter int HYST     = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_add,
    input  logic [DATA_W-1:0] i_res,
    input  logic [DATA_W-1:0] i_prev,
    input  logic              i_prev_vld,
    output logic [DATA_W-1:0] o_avg,
    output logic              o_pub
);

    localparam int ACC_W = DATA_W + AVG_LOG2;

    logic [ACC_W-1:0]  r_acc;
    logic [DATA_W-1:0] w_diff;

    // Clear wins over add: an aborted slot discards its last sample too.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_acc <= '0;
        end else if (i_add) begin
            r_acc <= r_acc + ACC_W'(i_res);
        end
    end

    assign o_avg  = r_acc[ACC_W-1:AVG_LOG2];
    assign w_diff = (o_avg >= i_prev) ? (o_avg - i_prev) : (i_prev - o_avg);
    assign o_pub  = !i_prev_vld || (32'(w_diff) > HYST);

endmodule

// File: rtl/pot_scan.sv
// Round-robin A2D sequencer: one conversion at a time per pot slot, averaged,
// hysteresis-filtered and published with a per-slot update strobe.
//
//   state  | meaning
//   IDLE   | scan disabled, no conversion outstanding
//   REQ    | strt_cnv asserted for one cycle on the current slot's channel
//   WAIT   | waiting for cnv_cmplt, timeout counter running
//   UPD    | average ready, publish if outside hysteresis, advance slot
module pot_scan
    import pot_scan_pkg::*;
#(
    parameter int                  NUM_CH      = 6,
    parameter int                  DATA_W      = 12,
    parameter int                  AVG_LOG2    = 2,
    parameter int                  HYST        = 8,
    parameter int                  TIMEOUT_CYC = 4096,
    parameter logic [3*NUM_CH-1:0] CH_MAP      = CH_MAP_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_en,
    output logic                     o_strt_cnv,
    output logic [2:0]               o_chnnl,
    input  logic                     i_cnv_cmplt,
    input  logic [DATA_W-1:0]        i_res,
    output logic [NUM_CH*DATA_W-1:0] o_pot_vals,
    output logic [NUM_CH-1:0]        o_upd,
    output logic [NUM_CH-1:0]        o_vld,
    output logic [NUM_CH-1:0]        o_err,
    output logic                     o_busy
);

    localparam int               CNT_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam int               TO_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

    state_t            r_state, w_next;
    logic [2:0]        r_slot, w_slot_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic [DATA_W-1:0] r_vals [NUM_CH];

    logic              w_add, w_clr, w_adv, w_cnt_inc, w_tmo;
    logic [DATA_W-1:0] w_avg, w_prev;
    logic              w_pub, w_prev_vld;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // cnv_cmplt is checked before the timeout so a same-cycle completion wins.
    always_comb begin
        w_next    = r_state;
        w_add     = 1'b0;
        w_clr     = 1'b0;
        w_adv     = 1'b0;
        w_cnt_inc = 1'b0;
        w_tmo     = 1'b0;
        case (r_state)
            S_IDLE: if (i_en) w_next = S_REQ;
            S_REQ:  w_next = S_WAIT;
            S_WAIT: begin
                if (i_cnv_cmplt) begin
                    w_add = 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        w_next = S_UPD;
                    end else if (i_en) begin
                        w_cnt_inc = 1'b1;
                        w_next    = S_REQ;
                    end else begin
                        w_clr  = 1'b1;
                        w_next = S_IDLE;
                    end
                end else if (r_to_cnt == TO_LAST) begin
                    w_tmo  = 1'b1;
                    w_clr  = 1'b1;
                    w_adv  = 1'b1;
                    w_next = i_en ? S_REQ : S_IDLE;
                end
            end
            S_UPD: begin
                w_clr  = 1'b1;
                w_adv  = 1'b1;
                w_next = i_en ? S_REQ : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_slot_nxt = w_adv ? slot_next(r_slot, NUM_CH) : r_slot;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_slot     <= '0;
            r_cnt      <= '0;
            o_strt_cnv <= 1'b0;
            o_chnnl    <= CH_MAP[2:0];
        end else begin
            r_slot     <= w_slot_nxt;
            o_strt_cnv <= (w_next == S_REQ);
            o_chnnl    <= CH_MAP[w_slot_nxt*3 +: 3];
            if (w_clr)          r_cnt <= '0;
            else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || r_state != S_WAIT) r_to_cnt <= '0;
        else                            r_to_cnt <= r_to_cnt + 1'b1;
    end

    assign w_prev     = r_vals[r_slot];
    assign w_prev_vld = o_vld[r_slot];

    pot_avg_hyst #(
        .DATA_W   (DATA_W),
        .AVG_LOG2 (AVG_LOG2),
        .HYST     (HYST)
    ) u_avg (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (w_clr),
        .i_add      (w_add),
        .i_res      (i_res),
        .i_prev     (w_prev),
        .i_prev_vld (w_prev_vld),
        .o_avg      (w_avg),
        .o_pub      (w_pub)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_upd <= '0;
            o_vld <= '0;
            o_err <= '0;
            for (int i = 0; i < NUM_CH; i++) r_vals[i] <= '0;
        end else begin
            o_upd <= '0;
            if (r_state == S_UPD && w_pub) begin
                o_upd[r_slot]  <= 1'b1;
                o_vld[r_slot]  <= 1'b1;
                r_vals[r_slot] <= w_avg;
            end
            if (w_tmo) o_err[r_slot] <= 1'b1;
        end
    end

    always_comb begin
        o_pot_vals = '0;
        for (int i = 0; i < NUM_CH; i++) o_pot_vals[i*DATA_W +: DATA_W] = r_vals[i];
    end

    assign o_busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_pot_scan.sv
// Bench for pot_scan: an A2D responder with random results/latencies and a
// per-slot reference model of averaging, hysteresis, timeout and enable.
module tb_pot_scan;

    logic        i_clk = 1'b0;
    logic        i_rst, i_en, i_cnv_cmplt;
    logic [11:0] i_res;
    logic        o_strt_cnv, o_busy;
    logic [2:0]  o_chnnl;
    logic [71:0] o_pot_vals;
    logic [5:0]  o_upd, o_vld, o_err;

    always #5 i_clk = ~i_clk;

    pot_scan dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_en        (i_en),
        .o_strt_cnv  (o_strt_cnv),
        .o_chnnl     (o_chnnl),
        .i_cnv_cmplt (i_cnv_cmplt),
        .i_res       (i_res),
        .o_pot_vals  (o_pot_vals),
        .o_upd       (o_upd),
        .o_vld       (o_vld),
        .o_err       (o_err),
        .o_busy      (o_busy)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          ch_tab [6] = '{1, 0, 4, 2, 3, 7};
    int          m_slot, m_cnt, m_sum;
    logic [11:0] m_val [6];
    bit          m_vld [6];
    bit          m_err [6];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] exp_vals();
        logic [71:0] r = '0;
        for (int i = 0; i < 6; i++) r[i*12 +: 12] = m_val[i];
        return r;
    endfunction

    function automatic logic [5:0] exp_vld();
        logic [5:0] r = '0;
        for (int i = 0; i < 6; i++) r[i] = m_vld[i];
        return r;
    endfunction

    function automatic logic [5:0] exp_err();
        logic [5:0] r = '0;
        for (int i = 0; i < 6; i++) r[i] = m_err[i];
        return r;
    endfunction

    function automatic logic [11:0] rnd_near();
        int v = int'(m_val[m_slot]) + int'($urandom_range(0, 32)) - 16;
        if (v < 0)    v = 0;
        if (v > 4095) v = 4095;
        return 12'(v);
    endfunction

    task automatic model_reset();
        m_slot = 0; m_cnt = 0; m_sum = 0;
        for (int i = 0; i < 6; i++) begin
            m_val[i] = '0; m_vld[i] = 0; m_err[i] = 0;
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_strt"}, o_strt_cnv, 0);
        chk({tag, "_chnnl"}, o_chnnl, 1);
        chk({tag, "_vals"}, o_pot_vals, 0);
        chk({tag, "_upd"}, o_upd, 0);
        chk({tag, "_vld"}, o_vld, 0);
        chk({tag, "_err"}, o_err, 0);
        chk({tag, "_busy"}, o_busy, 0);
    endtask

    task automatic wait_strt(output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (o_strt_cnv === 1'b1) begin
                ok = 1;
                break;
            end
            @(negedge i_clk);
        end
        chk("strt_cnv_seen", ok, 1);
        if (ok) chk("chnnl", o_chnnl, ch_tab[m_slot]);
    endtask

    // One conversion on the current model slot; lat = extra WAIT cycles before cnv_cmplt.
    task automatic conv(input logic [11:0] res, input int lat, input bit drop_en);
        bit ok;
        int s, avg, diff;
        bit pub;
        wait_strt(ok);
        if (!ok) return;
        s = m_slot;
        if (drop_en) i_en = 1'b0;
        repeat (1 + lat) @(negedge i_clk);
        i_cnv_cmplt = 1'b1;
        i_res       = res;
        @(negedge i_clk);
        i_cnv_cmplt = 1'b0;
        i_res       = 12'($urandom);
        m_sum += int'(res);
        if (m_cnt == 3) begin
            chk("busy_in_upd", o_busy, 1);
            avg  = m_sum >> 2;
            diff = (avg > int'(m_val[s])) ? avg - int'(m_val[s]) : int'(m_val[s]) - avg;
            pub  = !m_vld[s] || diff > 8;
            @(negedge i_clk);
            if (pub) begin
                m_val[s] = 12'(avg);
                m_vld[s] = 1;
            end
            chk("upd", o_upd, pub ? (6'd1 << s) : 6'd0);
            chk("pot_vals", o_pot_vals, exp_vals());
            chk("vld", o_vld, exp_vld());
            chk("err", o_err, exp_err());
            chk("strt_with_upd", o_strt_cnv, i_en);
            m_sum  = 0;
            m_cnt  = 0;
            m_slot = (s + 1) % 6;
        end else if (drop_en) begin
            chk("abort_busy", o_busy, 0);
            chk("abort_strt", o_strt_cnv, 0);
            chk("abort_upd", o_upd, 0);
            m_sum = 0;
            m_cnt = 0;
        end else begin
            chk("mid_upd", o_upd, 0);
            m_cnt++;
        end
    endtask

    task automatic tmo();
        bit ok;
        int s;
        wait_strt(ok);
        if (!ok) return;
        s = m_slot;
        repeat (4096) @(negedge i_clk);
        chk("err_before_expiry", o_err, exp_err());
        @(negedge i_clk);
        m_err[s] = 1;
        m_sum    = 0;
        m_cnt    = 0;
        m_slot   = (s + 1) % 6;
        chk("tmo_err", o_err, exp_err());
        chk("tmo_upd", o_upd, 0);
        chk("tmo_vals", o_pot_vals, exp_vals());
        chk("tmo_next_strt", o_strt_cnv, 1);
        chk("tmo_next_chnnl", o_chnnl, ch_tab[m_slot]);
    endtask

    task automatic slot_fix(input logic [11:0] a, input logic [11:0] b,
                            input logic [11:0] c, input logic [11:0] d);
        conv(a, $urandom_range(0, 4), 0);
        conv(b, $urandom_range(0, 4), 0);
        conv(c, $urandom_range(0, 4), 0);
        conv(d, $urandom_range(0, 4), 0);
    endtask

    task automatic slot_rand(input bit near);
        for (int i = 0; i < 4; i++)
            conv(near ? rnd_near() : 12'($urandom_range(0, 4095)), $urandom_range(0, 4), 0);
    endtask

    initial begin
        bit ok;
        i_rst = 1'b1; i_en = 1'b0; i_cnv_cmplt = 1'b0; i_res = '0;
        model_reset();
        repeat (3) @(negedge i_clk);
        check_reset("rst");
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("idle_busy", o_busy, 0);
        chk("idle_strt", o_strt_cnv, 0);
        i_en = 1'b1;
        @(negedge i_clk);
        chk("strt_after_en", o_strt_cnv, 1);
        chk("busy_after_en", o_busy, 1);

        // Round 1: full scale on every slot, publish order 0..5, wrap back to slot 0.
        repeat (6) slot_fix(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);

        // Round 2: slot 0 averaging, slot 1 enable drop, slot 2 completion on expiry cycle.
        slot_fix(12'h100, 12'h104, 12'h108, 12'h10C);
        chk("slot0_avg", o_pot_vals[11:0], 12'h106);
        conv(12'($urandom_range(0, 4095)), 1, 0);
        conv(12'($urandom_range(0, 4095)), 2, 1);
        i_en = 1'b1;
        slot_rand(0);
        conv(12'($urandom_range(0, 4095)), 4095, 0);
        for (int i = 0; i < 3; i++) conv(12'($urandom_range(0, 4095)), 0, 0);
        slot_rand(0);
        slot_rand(0);
        slot_fix(12'h800, 12'h800, 12'h800, 12'h800);

        // Round 3: slot 2 times out; slot 5 moves by exactly the threshold.
        slot_rand(0);
        slot_rand(0);
        tmo();
        slot_rand(0);
        slot_rand(0);
        slot_fix(12'h808, 12'h808, 12'h808, 12'h808);
        chk("hyst_hold", o_pot_vals[71:60], 12'h800);

        // Round 4/5: slot 5 just over the threshold, then a downward step.
        repeat (5) slot_rand(0);
        slot_fix(12'h805, 12'h80D, 12'h809, 12'h809);
        chk("hyst_up", o_pot_vals[71:60], 12'h809);
        repeat (5) slot_rand(0);
        slot_fix(12'h7F8, 12'h7F8, 12'h7F8, 12'h7F8);
        chk("hyst_down", o_pot_vals[71:60], 12'h7F8);

        repeat (12) slot_rand(1);
        repeat (6) slot_rand(0);

        // Reset in the middle of WAIT, with a stray completion right after.
        wait_strt(ok);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        check_reset("midrst");
        i_rst = 1'b0; i_en = 1'b0; i_cnv_cmplt = 1'b1; i_res = 12'hFFF;
        @(negedge i_clk);
        i_cnv_cmplt = 1'b0;
        model_reset();
        check_reset("late_cmplt");
        i_en = 1'b1;
        slot_fix(12'h200, 12'h200, 12'h200, 12'h200);
        slot_rand(0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
